// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and write-enable bit map for the execute stage.
// Holds no logic, so it has no latency and applies no backpressure.
package alu_pkg;

  localparam logic [3:0] OP_MOV = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL   = 2'd1,
    S_WB_RD = 2'd2,
    S_WB_ZF = 2'd3
  } state_t;

  localparam int REG_EN_Q0 = 0;
  localparam int REG_EN_Q1 = 1;
  localparam int REG_EN_Q2 = 2;
  localparam int REG_EN_Q3 = 3;
  localparam int REG_EN_ZF = 4;

  // Opcodes above CMP are NOPs: they never write a register or the zero flag.
  function automatic logic op_is_nop(input logic [3:0] op);
    return op > OP_CMP;
  endfunction

  function automatic logic op_writes_rd(input logic [3:0] op);
    return (op != OP_CMP) && !op_is_nop(op);
  endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Iterative shift-add multiplier. It returns the low WIDTH bits of a*b, and done rises MUL_CYCLES
// cycles after start. It applies no backpressure: a start while running restarts the multiplier.
module mul_shift_add #(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  logic             run;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;

  // The load edge already folds in bit 0, so MUL_CYCLES-1 further steps remain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run    <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= CW'(MUL_CYCLES - 1);
      acc    <= b[0] ? a : '0;
      mcand  <= a << 1;
      mplier <= b >> 1;
    end else if (run) begin
      if (cnt == '0) begin
        run <= 1'b0;
      end else begin
        acc    <= acc + (mplier[0] ? mcand : '0);
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
      end
    end
  end

  assign done = run && (cnt == '0);
  assign prod = acc;

endmodule

// File: rtl/alu_exec.sv
// Execute and write-back stage: one ALU op, then an rd beat and a zero-flag beat. Non-MUL ops
// finish in 3 cycles and MUL in MUL_CYCLES+3. en_in is ignored while busy.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_in,
  input  logic [WIDTH-1:0] rd_q,
  input  logic [WIDTH-1:0] rs_q,
  input  logic [3:0]       op,
  input  logic [1:0]       rd_sel,
  output logic [WIDTH-1:0] d_out,
  output logic [4:0]       reg_en,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  logic [3:0]       op_q, op_cur;
  logic [1:0]       sel_q, sel_cur;
  logic [WIDTH-1:0] res, res_nxt, alu_res, mul_prod;
  logic             mul_start, mul_done, start;
  logic [WIDTH-1:0] d_nxt;
  logic [4:0]       en_nxt;
  logic             busy_nxt, done_nxt;

  assign start     = (state == S_IDLE) && en_in;
  assign mul_start = start && (op == OP_MUL);

  mul_shift_add #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (rd_q),
    .b     (rs_q),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_comb begin
    alu_res = '0;
    case (op)
      OP_MOV:  alu_res = rs_q;
      OP_ADD:  alu_res = rd_q + rs_q;
      OP_SUB:  alu_res = rd_q - rs_q;
      OP_AND:  alu_res = rd_q & rs_q;
      OP_OR:   alu_res = rd_q | rs_q;
      OP_XOR:  alu_res = rd_q ^ rs_q;
      OP_NOT:  alu_res = ~rd_q;
      OP_SHL:  alu_res = rd_q << rs_q[3:0];
      OP_SHR:  alu_res = rd_q >> rs_q[3:0];
      OP_CMP:  alu_res = rd_q - rs_q;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (en_in) state_nxt = (op == OP_MUL) ? S_MUL : S_WB_RD;
      S_MUL:   if (mul_done) state_nxt = S_WB_RD;
      S_WB_RD: state_nxt = S_WB_ZF;
      default: state_nxt = S_IDLE;
    endcase
  end

  // In IDLE the live inputs decide the first beat; afterwards only the captured copies are used.
  always_comb begin
    op_cur  = (state == S_IDLE) ? op : op_q;
    sel_cur = (state == S_IDLE) ? rd_sel : sel_q;
    case (state)
      S_IDLE:  res_nxt = alu_res;
      S_MUL:   res_nxt = mul_prod;
      default: res_nxt = res;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      sel_q <= '0;
      res   <= '0;
    end else if (start) begin
      op_q  <= op;
      sel_q <= rd_sel;
      res   <= res_nxt;
    end else if ((state == S_MUL) && mul_done) begin
      res <= res_nxt;
    end
  end

  always_comb begin
    d_nxt    = '0;
    en_nxt   = '0;
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_nxt)
      S_MUL: busy_nxt = 1'b1;
      S_WB_RD: begin
        busy_nxt = 1'b1;
        d_nxt    = res_nxt;
        if (op_writes_rd(op_cur)) begin
          case (sel_cur)
            2'd0:    en_nxt[REG_EN_Q0] = 1'b1;
            2'd1:    en_nxt[REG_EN_Q1] = 1'b1;
            2'd2:    en_nxt[REG_EN_Q2] = 1'b1;
            default: en_nxt[REG_EN_Q3] = 1'b1;
          endcase
        end
      end
      S_WB_ZF: begin
        busy_nxt          = 1'b1;
        done_nxt          = 1'b1;
        d_nxt             = {{(WIDTH-1){1'b0}}, (res == '0)};
        en_nxt[REG_EN_ZF] = !op_is_nop(op_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out  <= '0;
      reg_en <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      d_out  <= d_nxt;
      reg_en <= en_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed vector bench for alu_exec: single-op table plus MUL, back-to-back and reset sequences.
module tb_alu_exec;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_in;
  logic [15:0] rd_q, rs_q;
  logic [3:0]  op;
  logic [1:0]  rd_sel;
  logic [15:0] d_out;
  logic [4:0]  reg_en;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  alu_exec dut (
    .clk    (clk),
    .rst    (rst),
    .en_in  (en_in),
    .rd_q   (rd_q),
    .rs_q   (rs_q),
    .op     (op),
    .rd_sel (rd_sel),
    .d_out  (d_out),
    .reg_en (reg_en),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    logic [1:0]  sel;
    logic        chk_d;
    logic [15:0] d1;
    logic [4:0]  en1;
    logic [15:0] d2;
    logic [4:0]  en2;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] s);
    @(negedge clk);
    op = o; rd_q = a; rs_q = b; rd_sel = s; en_in = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] s, input logic [15:0] exp_p);
    start_op(OP_MUL, a, b, s);
    // en_in stays high with different operands: the running MUL must ignore them.
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("%s busy T+%0d", tag, k), {busy, reg_en, done}, {1'b1, 5'b00000, 1'b0});
      @(negedge clk);
      op = OP_ADD; rd_q = 16'hFFFF; rs_q = 16'hFFFF;
      @(posedge clk); #1;
    end
    chk({tag, " T+17 d_out"}, d_out, exp_p);
    chk({tag, " T+17 reg_en/done"}, {reg_en, done}, {5'b00001 << s, 1'b0});
    @(negedge clk); en_in = 1'b0;
    @(posedge clk); #1;
    chk({tag, " T+18 zf beat"}, {d_out, reg_en, done, busy},
        {15'd0, exp_p == 16'h0, 5'b10000, 1'b1, 1'b1});
    @(posedge clk); #1;
    chk({tag, " T+19 idle"}, {reg_en, done, busy}, 7'd0);
  endtask

  initial begin
    vt[0]  = '{OP_MOV, 16'h1111, 16'hBEEF, 2'd1, 1'b1, 16'hBEEF, 5'b00010, 16'h0000, 5'b10000};
    vt[1]  = '{OP_ADD, 16'hFFFF, 16'h0001, 2'd2, 1'b1, 16'h0000, 5'b00100, 16'h0001, 5'b10000};
    vt[2]  = '{OP_SUB, 16'h1234, 16'h0034, 2'd0, 1'b1, 16'h1200, 5'b00001, 16'h0000, 5'b10000};
    vt[3]  = '{OP_AND, 16'hF0F0, 16'h3C3C, 2'd3, 1'b1, 16'h3030, 5'b01000, 16'h0000, 5'b10000};
    vt[4]  = '{OP_OR,  16'h0F00, 16'h00F0, 2'd1, 1'b1, 16'h0FF0, 5'b00010, 16'h0000, 5'b10000};
    vt[5]  = '{OP_XOR, 16'hAAAA, 16'hAAAA, 2'd0, 1'b1, 16'h0000, 5'b00001, 16'h0001, 5'b10000};
    vt[6]  = '{OP_NOT, 16'h00FF, 16'h1234, 2'd2, 1'b1, 16'hFF00, 5'b00100, 16'h0000, 5'b10000};
    vt[7]  = '{OP_SHL, 16'h0001, 16'h0013, 2'd3, 1'b1, 16'h0008, 5'b01000, 16'h0000, 5'b10000};
    vt[8]  = '{OP_SHR, 16'h8000, 16'h000F, 2'd0, 1'b1, 16'h0001, 5'b00001, 16'h0000, 5'b10000};
    vt[9]  = '{OP_CMP, 16'h00AA, 16'h00AA, 2'd1, 1'b1, 16'h0000, 5'b00000, 16'h0001, 5'b10000};
    vt[10] = '{OP_CMP, 16'h0005, 16'h0003, 2'd2, 1'b1, 16'h0002, 5'b00000, 16'h0000, 5'b10000};
    vt[11] = '{4'd12,  16'h1234, 16'h5678, 2'd3, 1'b0, 16'h0000, 5'b00000, 16'h0000, 5'b00000};
    vt[12] = '{OP_SUB, 16'h0000, 16'h0001, 2'd1, 1'b1, 16'hFFFF, 5'b00010, 16'h0000, 5'b10000};

    rst = 1'b1; en_in = 1'b0; rd_q = '0; rs_q = '0; op = '0; rd_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {d_out, reg_en, busy, done}, 23'd0);
    @(negedge clk); rst = 1'b0;

    foreach (vt[i]) begin
      start_op(vt[i].op, vt[i].a, vt[i].b, vt[i].sel);
      if (vt[i].chk_d) chk($sformatf("vec%0d T+1 d_out", i), d_out, vt[i].d1);
      chk($sformatf("vec%0d T+1 en/busy/done", i), {reg_en, busy, done}, {vt[i].en1, 2'b10});
      @(negedge clk); en_in = 1'b0; rd_q = 16'h5A5A; rs_q = 16'hA5A5; op = OP_ADD;
      @(posedge clk); #1;
      if (vt[i].chk_d) chk($sformatf("vec%0d T+2 d_out", i), d_out, vt[i].d2);
      chk($sformatf("vec%0d T+2 en/busy/done", i), {reg_en, busy, done}, {vt[i].en2, 2'b11});
      @(posedge clk); #1;
      chk($sformatf("vec%0d T+3 idle", i), {d_out, reg_en, busy, done}, 23'd0);
    end

    // Back-to-back: en_in held high restarts at T+3.
    start_op(OP_MOV, 16'h0000, 16'h0042, 2'd1);
    @(posedge clk); #1;
    chk("b2b T+2 done", {reg_en, done}, {5'b10000, 1'b1});
    @(posedge clk); #1;
    chk("b2b T+3 idle", {reg_en, busy, done}, 7'd0);
    @(posedge clk); #1;
    chk("b2b T+4 restart", {d_out, reg_en, busy}, {16'h0042, 5'b00010, 1'b1});
    @(negedge clk); en_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("b2b drain idle", {reg_en, busy, done}, 7'd0);

    run_mul("mul1", 16'h0123, 16'h0010, 2'd3, 16'h1230);
    run_mul("mul2", 16'h00FF, 16'h0101, 2'd0, 16'hFFFF);
    run_mul("mul3", 16'h8000, 16'h0002, 2'd2, 16'h0000);

    // Reset at T+8 of a MUL aborts it with no later write-back.
    start_op(OP_MUL, 16'h0123, 16'h0010, 2'd3);
    @(negedge clk); en_in = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mul busy before rst", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("async rst outputs", {d_out, reg_en, busy, done}, 23'd0);
    @(negedge clk); rst = 1'b0;
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 25; k++) begin
        @(posedge clk); #1;
        if (reg_en !== 5'd0 || busy !== 1'b0 || done !== 1'b0) bad++;
      end
      chk("no write after rst", bad, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
